// File: rtl/intr_ctrl_axil_slave.sv
// rtl/intr_ctrl_axil_slave.sv - AXI4-Lite interrupt controller slave with sticky status and W1C acknowledge
module intr_ctrl_axil_slave #(
    parameter int          C_S_AXI_DATA_WIDTH  = 32,
    parameter int          C_S_AXI_ADDR_WIDTH  = 5,
    parameter int          C_NUM_OF_INTR       = 1,
    parameter logic [31:0] C_INTR_SENSITIVITY  = 32'hFFFF_FFFF,
    parameter logic [31:0] C_INTR_ACTIVE_STATE = 32'hFFFF_FFFF,
    parameter logic        C_IRQ_ACTIVE_STATE  = 1'b1
) (
    input  logic                            s_axi_intr_aclk,
    input  logic                            s_axi_intr_aresetn,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   s_axi_intr_awaddr,
    input  logic [2:0]                      s_axi_intr_awprot,
    input  logic                            s_axi_intr_awvalid,
    output logic                            s_axi_intr_awready,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]   s_axi_intr_wdata,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0] s_axi_intr_wstrb,
    input  logic                            s_axi_intr_wvalid,
    output logic                            s_axi_intr_wready,
    output logic [1:0]                      s_axi_intr_bresp,
    output logic                            s_axi_intr_bvalid,
    input  logic                            s_axi_intr_bready,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   s_axi_intr_araddr,
    input  logic [2:0]                      s_axi_intr_arprot,
    input  logic                            s_axi_intr_arvalid,
    output logic                            s_axi_intr_arready,
    output logic [C_S_AXI_DATA_WIDTH-1:0]   s_axi_intr_rdata,
    output logic [1:0]                      s_axi_intr_rresp,
    output logic                            s_axi_intr_rvalid,
    input  logic                            s_axi_intr_rready,
    input  logic [C_NUM_OF_INTR-1:0]        intr_in,
    output logic                            irq
);

    // Bits at or above the source count are never stored and read back as 0.
    localparam logic [32:0] NMASK_EXT  = (33'd1 << C_NUM_OF_INTR) - 33'd1;
    localparam logic [31:0] VALID_MASK = NMASK_EXT[31:0];

    localparam logic [2:0] SEL_GIE = 3'd0;
    localparam logic [2:0] SEL_IER = 3'd1;
    localparam logic [2:0] SEL_ISR = 3'd2;
    localparam logic [2:0] SEL_IAR = 3'd3;
    localparam logic [2:0] SEL_IPR = 3'd4;

    typedef enum logic {W_IDLE, W_RESP} wr_state_t;
    typedef enum logic {R_IDLE, R_DATA} rd_state_t;

    wr_state_t   wr_state;
    rd_state_t   rd_state;

    logic        gie;
    logic [31:0] ier;
    logic [31:0] isr;
    logic [31:0] act;
    logic [31:0] act_prev;
    logic [31:0] set_bits;
    logic [31:0] ack_clr;
    logic [31:0] strb_mask;
    logic [31:0] wr_bits;
    logic [31:0] rd_mux;
    logic [2:0]  wr_sel;
    logic [2:0]  rd_sel;
    logic        wr_en;
    logic        rd_en;
    logic        unused_ok;

    assign unused_ok = ^{s_axi_intr_awprot, s_axi_intr_arprot,
                         s_axi_intr_awaddr[1:0], s_axi_intr_araddr[1:0]};

    assign s_axi_intr_bresp = 2'b00;
    assign s_axi_intr_rresp = 2'b00;

    // A write or read is taken on the edge where our ready meets the master's valid.
    assign wr_en  = s_axi_intr_awready & s_axi_intr_awvalid & s_axi_intr_wready & s_axi_intr_wvalid;
    assign rd_en  = s_axi_intr_arready & s_axi_intr_arvalid;
    assign wr_sel = s_axi_intr_awaddr[4:2];
    assign rd_sel = s_axi_intr_araddr[4:2];

    // Per-source active detection; sources beyond the configured count are tied inactive.
    for (genvar i = 0; i < 32; i++) begin : g_act
        if (i < C_NUM_OF_INTR) begin : g_src
            assign act[i] = (intr_in[i] == C_INTR_ACTIVE_STATE[i]);
        end else begin : g_none
            assign act[i] = 1'b0;
        end
    end

    // Byte-lane mask built from wstrb.
    for (genvar k = 0; k < 4; k++) begin : g_strb
        assign strb_mask[8*k +: 8] = {8{s_axi_intr_wstrb[k]}};
    end

    assign wr_bits  = s_axi_intr_wdata & strb_mask;
    assign set_bits = (C_INTR_SENSITIVITY & act & ~act_prev) | (~C_INTR_SENSITIVITY & act);
    assign ack_clr  = (wr_en && wr_sel == SEL_IAR) ? (wr_bits & VALID_MASK) : 32'd0;

    // Register read multiplexer; unmapped offsets and IAR read as zero.
    always_comb begin
        rd_mux = 32'd0;
        case (rd_sel)
            SEL_GIE: rd_mux = {31'd0, gie};
            SEL_IER: rd_mux = ier;
            SEL_ISR: rd_mux = isr;
            SEL_IPR: rd_mux = isr & ier;
            default: rd_mux = 32'd0;
        endcase
    end

    // Enable registers, byte-lane gated.
    always_ff @(posedge s_axi_intr_aclk or negedge s_axi_intr_aresetn) begin
        if (!s_axi_intr_aresetn) begin
            gie <= 1'b0;
            ier <= 32'd0;
        end else if (wr_en) begin
            if (wr_sel == SEL_GIE && s_axi_intr_wstrb[0])
                gie <= s_axi_intr_wdata[0];
            if (wr_sel == SEL_IER)
                ier <= ((ier & ~strb_mask) | wr_bits) & VALID_MASK;
        end
    end

    // Sticky status with edge history; a new set beats an acknowledge on the same edge.
    always_ff @(posedge s_axi_intr_aclk or negedge s_axi_intr_aresetn) begin
        if (!s_axi_intr_aresetn) begin
            isr      <= 32'd0;
            act_prev <= 32'd0;
        end else begin
            isr      <= (isr & ~ack_clr) | set_bits;
            act_prev <= act;
        end
    end

    // Registered interrupt request from enabled pending status.
    always_ff @(posedge s_axi_intr_aclk or negedge s_axi_intr_aresetn) begin
        if (!s_axi_intr_aresetn)
            irq <= ~C_IRQ_ACTIVE_STATE;
        else if (gie && |(isr & ier))
            irq <= C_IRQ_ACTIVE_STATE;
        else
            irq <= ~C_IRQ_ACTIVE_STATE;
    end

    // Write channel FSM: one-cycle AW/W ready pulse, then hold the response until accepted.
    always_ff @(posedge s_axi_intr_aclk or negedge s_axi_intr_aresetn) begin
        if (!s_axi_intr_aresetn) begin
            wr_state           <= W_IDLE;
            s_axi_intr_awready <= 1'b0;
            s_axi_intr_wready  <= 1'b0;
            s_axi_intr_bvalid  <= 1'b0;
        end else begin
            case (wr_state)
                W_IDLE: begin
                    if (s_axi_intr_awready) begin
                        s_axi_intr_awready <= 1'b0;
                        s_axi_intr_wready  <= 1'b0;
                        if (wr_en) begin
                            s_axi_intr_bvalid <= 1'b1;
                            wr_state          <= W_RESP;
                        end
                    end else if (s_axi_intr_awvalid && s_axi_intr_wvalid) begin
                        s_axi_intr_awready <= 1'b1;
                        s_axi_intr_wready  <= 1'b1;
                    end
                end
                W_RESP: begin
                    if (s_axi_intr_bready) begin
                        s_axi_intr_bvalid <= 1'b0;
                        wr_state          <= W_IDLE;
                    end
                end
                default: wr_state <= W_IDLE;
            endcase
        end
    end

    // Read channel FSM: one-cycle AR ready pulse, data captured then held until accepted.
    always_ff @(posedge s_axi_intr_aclk or negedge s_axi_intr_aresetn) begin
        if (!s_axi_intr_aresetn) begin
            rd_state           <= R_IDLE;
            s_axi_intr_arready <= 1'b0;
            s_axi_intr_rvalid  <= 1'b0;
            s_axi_intr_rdata   <= '0;
        end else begin
            case (rd_state)
                R_IDLE: begin
                    if (s_axi_intr_arready) begin
                        s_axi_intr_arready <= 1'b0;
                        if (rd_en) begin
                            s_axi_intr_rdata  <= rd_mux;
                            s_axi_intr_rvalid <= 1'b1;
                            rd_state          <= R_DATA;
                        end
                    end else if (s_axi_intr_arvalid) begin
                        s_axi_intr_arready <= 1'b1;
                    end
                end
                R_DATA: begin
                    if (s_axi_intr_rready) begin
                        s_axi_intr_rvalid <= 1'b0;
                        rd_state          <= R_IDLE;
                    end
                end
                default: rd_state <= R_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_intr_ctrl_axil_slave.sv
// tb/tb_intr_ctrl_axil_slave.sv - directed self-checking bench for intr_ctrl_axil_slave
module tb_intr_ctrl_axil_slave;

    logic        aclk;
    logic        aresetn;
    logic [4:0]  awaddr;
    logic [2:0]  awprot;
    logic        awvalid;
    logic        awready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wvalid;
    logic        wready;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready;
    logic [4:0]  araddr;
    logic [2:0]  arprot;
    logic        arvalid;
    logic        arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid;
    logic        rready;
    logic [1:0]  intr_in;
    logic        irq;

    int vec_count  = 0;
    int miscompares = 0;

    intr_ctrl_axil_slave #(
        .C_S_AXI_DATA_WIDTH (32),
        .C_S_AXI_ADDR_WIDTH (5),
        .C_NUM_OF_INTR      (2),
        .C_INTR_SENSITIVITY (32'hFFFF_FFFD),
        .C_INTR_ACTIVE_STATE(32'hFFFF_FFFF),
        .C_IRQ_ACTIVE_STATE (1'b1)
    ) dut (
        .s_axi_intr_aclk   (aclk),
        .s_axi_intr_aresetn(aresetn),
        .s_axi_intr_awaddr (awaddr),
        .s_axi_intr_awprot (awprot),
        .s_axi_intr_awvalid(awvalid),
        .s_axi_intr_awready(awready),
        .s_axi_intr_wdata  (wdata),
        .s_axi_intr_wstrb  (wstrb),
        .s_axi_intr_wvalid (wvalid),
        .s_axi_intr_wready (wready),
        .s_axi_intr_bresp  (bresp),
        .s_axi_intr_bvalid (bvalid),
        .s_axi_intr_bready (bready),
        .s_axi_intr_araddr (araddr),
        .s_axi_intr_arprot (arprot),
        .s_axi_intr_arvalid(arvalid),
        .s_axi_intr_arready(arready),
        .s_axi_intr_rdata  (rdata),
        .s_axi_intr_rresp  (rresp),
        .s_axi_intr_rvalid (rvalid),
        .s_axi_intr_rready (rready),
        .intr_in           (intr_in),
        .irq               (irq)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vec_count++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic axi_write(input logic [4:0] addr, input logic [31:0] data,
                             input logic [3:0] strb, input bit pulse0);
        int n;
        @(negedge aclk);
        awaddr = addr; wdata = data; wstrb = strb;
        awvalid = 1'b1; wvalid = 1'b1; bready = 1'b1;
        n = 0;
        do begin @(negedge aclk); n++; end while (!awready && n < 50);
        if (!awready) begin
            check_val("aw_timeout", 32'd0, 32'd1);
            awvalid = 1'b0; wvalid = 1'b0;
            return;
        end
        if (pulse0) intr_in[0] = 1'b1;
        @(posedge aclk);
        #1;
        awvalid = 1'b0; wvalid = 1'b0;
        @(negedge aclk);
        if (pulse0) intr_in[0] = 1'b0;
        check_val("wr_bvalid_bresp", {bvalid, bresp}, 32'h4);
    endtask

    task automatic axi_read(input logic [4:0] addr, output logic [31:0] data);
        int n;
        @(negedge aclk);
        araddr = addr; arvalid = 1'b1; rready = 1'b1;
        n = 0;
        do begin @(negedge aclk); n++; end while (!arready && n < 50);
        if (!arready) begin
            check_val("ar_timeout", 32'd0, 32'd1);
            arvalid = 1'b0;
            data = 32'hDEAD_BEEF;
            return;
        end
        @(posedge aclk);
        #1;
        arvalid = 1'b0;
        @(negedge aclk);
        check_val("rd_rvalid_rresp", {rvalid, rresp}, 32'h4);
        data = rdata;
    endtask

    task automatic read_check(input string tag, input logic [4:0] addr, input logic [31:0] exp);
        logic [31:0] d;
        axi_read(addr, d);
        check_val(tag, d, exp);
    endtask

    // One-cycle pulse on source 0; irq is checked one and two cycles after the sampling edge.
    task automatic pulse_src0(input logic exp_irq);
        @(negedge aclk);
        intr_in[0] = 1'b1;
        @(negedge aclk);
        intr_in[0] = 1'b0;
        check_val("pulse_irq_n1", irq, 32'd0);
        @(negedge aclk);
        check_val("pulse_irq_n2", irq, exp_irq);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        aresetn = 1'b0;
        awaddr = '0; awprot = '0; awvalid = 1'b0; wdata = '0; wstrb = '0; wvalid = 1'b0;
        bready = 1'b1; araddr = '0; arprot = '0; arvalid = 1'b0; rready = 1'b1;
        intr_in = 2'b00;

        // Reset
        #100;
        @(negedge aclk);
        check_val("rst_irq", irq, 32'd0);
        check_val("rst_handshake", {awready, wready, arready, bvalid, rvalid}, 32'd0);
        check_val("rst_rdata", rdata, 32'd0);
        aresetn = 1'b1;
        read_check("rst_gie", 5'h00, 32'd0);
        read_check("rst_ier", 5'h04, 32'd0);
        read_check("rst_isr", 5'h08, 32'd0);
        read_check("rst_iar", 5'h0C, 32'd0);
        read_check("rst_ipr", 5'h10, 32'd0);

        // Basic flow
        axi_write(5'h00, 32'h1, 4'hF, 0);
        axi_write(5'h04, 32'h1, 4'hF, 0);
        read_check("basic_gie", 5'h00, 32'h1);
        pulse_src0(1'b1);
        read_check("basic_ipr", 5'h10, 32'h1);
        axi_write(5'h0C, 32'h1, 4'hF, 0);
        check_val("iar_irq_n1", irq, 32'd1);
        @(negedge aclk);
        check_val("iar_irq_n2", irq, 32'd0);
        read_check("basic_ipr_clr", 5'h10, 32'h0);

        // Masking by IER
        axi_write(5'h04, 32'h0, 4'hF, 0);
        pulse_src0(1'b0);
        read_check("mask_isr", 5'h08, 32'h1);
        read_check("mask_ipr", 5'h10, 32'h0);
        check_val("mask_irq", irq, 32'd0);
        axi_write(5'h04, 32'h1, 4'hF, 0);
        check_val("ier_irq_n1", irq, 32'd0);
        @(negedge aclk);
        check_val("ier_irq_n2", irq, 32'd1);

        // Set/clear collision: new edge on the acknowledge edge keeps the bit
        axi_write(5'h0C, 32'h1, 4'hF, 1);
        check_val("coll_irq_n1", irq, 32'd1);
        @(negedge aclk);
        check_val("coll_irq_n2", irq, 32'd1);
        read_check("coll_isr", 5'h08, 32'h1);

        // Global enable gating
        axi_write(5'h00, 32'h0, 4'hF, 0);
        check_val("gie_irq_n1", irq, 32'd1);
        @(negedge aclk);
        check_val("gie_irq_n2", irq, 32'd0);
        axi_write(5'h0C, 32'h1, 4'hF, 0);
        read_check("gie_isr_clr", 5'h08, 32'h0);
        axi_write(5'h00, 32'h1, 4'hF, 0);

        // Level mode on source 1
        axi_write(5'h04, 32'h2, 4'hF, 0);
        @(negedge aclk);
        intr_in[1] = 1'b1;
        @(negedge aclk);
        @(negedge aclk);
        check_val("lvl_irq", irq, 32'd1);
        axi_write(5'h0C, 32'h2, 4'hF, 0);
        read_check("lvl_isr_held", 5'h08, 32'h2);
        @(negedge aclk);
        intr_in[1] = 1'b0;
        axi_write(5'h0C, 32'h2, 4'hF, 0);
        read_check("lvl_isr_clr", 5'h08, 32'h0);
        check_val("lvl_irq_off", irq, 32'd0);

        // Back-pressure on B: response held, no second write taken
        @(negedge aclk);
        bready = 1'b0;
        awaddr = 5'h04; wdata = 32'h3; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
        n = 0;
        do begin @(negedge aclk); n++; end while (!awready && n < 50);
        check_val("bp_awready", awready, 32'd1);
        @(posedge aclk);
        #1;
        wdata = 32'h0;
        for (int i = 0; i < 10; i++) begin
            @(negedge aclk);
            check_val("bp_hold", {bvalid, awready}, 32'h2);
        end
        bready = 1'b1; awvalid = 1'b0; wvalid = 1'b0;
        @(negedge aclk);
        check_val("bp_release", bvalid, 32'd0);
        read_check("bp_ier", 5'h04, 32'h3);

        // Unmapped offsets and byte strobes
        read_check("unmapped_18", 5'h18, 32'h0);
        axi_write(5'h14, 32'hFFFF_FFFF, 4'hF, 0);
        read_check("unmapped_wr_ier", 5'h04, 32'h3);
        read_check("unmapped_wr_gie", 5'h00, 32'h1);
        axi_write(5'h04, 32'h0, 4'h0, 0);
        read_check("strb0_ier", 5'h04, 32'h3);
        axi_write(5'h04, 32'hFFFF_FF00, 4'h1, 0);
        read_check("strb1_ier", 5'h04, 32'h0);
        axi_write(5'h04, 32'hFFFF_FFFF, 4'hF, 0);
        read_check("ier_upper_zero", 5'h04, 32'h3);

        $display("== %0d vectors applied, %0d miscompares ==", vec_count, miscompares);
        $finish;
    end

endmodule
